fetch_unit: RTL

- Instruction fetch front end that produces the 16-bit instruction stream consumed by the opcode decoder (opcode field inst[15:12]).
- Issues one read at a time to instruction memory over a req/rvalid handshake with variable latency.
- Buffers fetched words in a small FIFO and presents them to decode through a valid/ready handshake.
- Services branch redirects from execute by flushing the buffer and discarding any in-flight response.

---
 rtl/fetch_unit_pkg.sv | 33 +++
 rtl/fetch_buf.sv | 79 +++++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch front end: the opcode field
// encodings understood by the control decoder and a helper that classifies
// an opcode as legal or illegal.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    // Opcode field inst[15:12]
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SHL = 4'h5;
    localparam logic [3:0] OP_SHR = 4'h6;
    localparam logic [3:0] OP_MUL = 4'h7;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hA;

    // Anything outside the decoded set is flagged; the word still flows on.
    function automatic logic op_is_illegal(input logic [3:0] op);
        logic illegal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL,
            OP_LW, OP_SW, OP_BEQ: illegal = 1'b0;
            default:              illegal = 1'b1;
        endcase
        return illegal;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// DEPTH-entry registered FIFO of {instruction word, word address}.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   push, push_inst,     write an entry (accepted when not full, or when a
//   push_pc              pop happens in the same cycle)
//   pop                  drop the head entry (ignored when empty)
//   flush                empty the FIFO; overrides push and pop
//   head_inst, head_pc   current head entry (undefined while empty)
//   count, full, empty   occupancy status
// -----------------------------------------------------------------------------
module fetch_buf #(
    parameter int AW    = 8,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [15:0]   push_inst,
    input  logic [AW-1:0] push_pc,
    input  logic          pop,
    input  logic          flush,
    output logic [15:0]   head_inst,
    output logic [AW-1:0] head_pc,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [15:0]   inst_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign pop_ok  = pop && !empty;
    // A full FIFO can still take a push when the head leaves this cycle.
    assign push_ok = push && (!full || pop_ok);

    // Storage carries no reset; its contents are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            inst_mem[wr_ptr] <= push_inst;
            pc_mem[wr_ptr]   <= push_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_inst = inst_mem[rd_ptr];
    assign head_pc   = pc_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Issues one instruction-memory read at a time,
// buffers returned words in fetch_buf and hands them to decode over a
// valid/ready handshake. A redirect flushes the buffer, restarts fetch at
// redirect_pc and discards any response still in flight.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req, imem_addr      single-cycle read request and word address
//   imem_rvalid, imem_rdata  read response (one per request)
//   inst_valid, inst_ready   decode handshake
//   inst, inst_pc            head instruction word and its address
//   op, inst_illegal         opcode field and illegal-opcode flag
//   redirect, redirect_pc    branch redirect pulse and restart address
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int            AW       = 8,
    parameter int            DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rvalid,
    input  logic [15:0]   imem_rdata,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [15:0]   inst,
    output logic [AW-1:0] inst_pc,
    output logic [3:0]    op,
    output logic          inst_illegal,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [AW-1:0] fetch_pc;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          buf_full;
    logic          buf_empty;
    logic [15:0]   head_inst;
    logic [AW-1:0] head_pc;

    // Redirect wins over everything: no push of a response and no pop by decode.
    assign push        = (state == S_WAIT) && imem_rvalid && !redirect;
    assign pop         = inst_valid && inst_ready && !redirect;
    assign count_after = count + CW'(push) - CW'(pop);

    fetch_buf #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_inst (imem_rdata),
        .push_pc   (fetch_pc),
        .pop       (pop),
        .flush     (redirect),
        .head_inst (head_inst),
        .head_pc   (head_pc),
        .count     (count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!redirect && (count < DEPTH_C)) state_nxt = S_REQ;
            end
            S_REQ: begin
                // The request goes out this cycle regardless; its response
                // must be swallowed if a redirect arrives alongside.
                state_nxt = redirect ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (redirect) begin
                    state_nxt = imem_rvalid ? S_IDLE : S_DROP;
                end else if (imem_rvalid) begin
                    state_nxt = (count_after < DEPTH_C) ? S_REQ : S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (push) begin
                fetch_pc <= fetch_pc + AW'(1);
            end
        end
    end

    assign imem_req  = (state == S_REQ);
    assign imem_addr = imem_req ? fetch_pc : '0;

    // Head fields are forced to zero while the buffer is empty so the
    // decode-facing outputs are clean out of reset without resetting storage.
    assign inst_valid   = !buf_empty;
    assign inst         = inst_valid ? head_inst : 16'h0000;
    assign inst_pc      = inst_valid ? head_pc : '0;
    assign op           = inst[15:12];
    assign inst_illegal = op_is_illegal(op);

    logic unused_full;
    assign unused_full = buf_full;

endmodule
